subset_decode_param: RTL

Parametrised, pipelined successor to the fixed 8-input/4-subset Viterbi subset decoder. For each of NSUB subsets it compares metric i against metric i+NSUB and outputs the smaller metric plus a 1-bit select. It also reports the global best subset (argmin) and its metric. Adds valid/ready flow control with backpressure, and sits between the branch-metric unit and the ACS/trellis stage.

---
 rtl/subset_decode_param_if.sv | 28 ++
 rtl/subset_decode_param.sv | 86 ++++++++
 2 files changed

// File: rtl/subset_decode_param_if.sv
// Handshake and result bundle for subset_decode_param: input metrics with
// valid/ready on one side, decoded subset results with valid/ready on the other.
interface subset_decode_param_if #(
  parameter int unsigned W    = 3,
  parameter int unsigned NSUB = 4
);
  localparam int unsigned IDXW = $clog2(NSUB);

  logic                   in_valid;
  logic                   in_ready;
  logic [2*NSUB*W-1:0]    in_metrics;
  logic                   out_valid;
  logic                   out_ready;
  logic [NSUB*W-1:0]      s;
  logic [NSUB-1:0]        sout;
  logic [IDXW-1:0]        best_idx;
  logic [W-1:0]           best_metric;

  modport master (
    output in_valid, in_metrics, out_ready,
    input  in_ready, out_valid, s, sout, best_idx, best_metric
  );

  modport slave (
    input  in_valid, in_metrics, out_ready,
    output in_ready, out_valid, s, sout, best_idx, best_metric
  );
endinterface

// File: rtl/subset_decode_param.sv
// Two-stage subset decoder: per-subset min/select of metric i vs i+NSUB,
// plus argmin over subsets, behind a valid/ready pipeline with backpressure.
module subset_decode_param #(
  parameter int unsigned W      = 3,
  parameter int unsigned NSUB   = 4,
  parameter int unsigned TIE_HI = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  subset_decode_param_if.slave bus
);
  localparam int unsigned IDXW      = $clog2(NSUB);
  localparam bit          TIE_UPPER = (TIE_HI != 0);

  logic                   v1_q;
  logic                   v2_q;
  logic [2*NSUB*W-1:0]    m1_q;
  logic [NSUB*W-1:0]      s_q, s_d;
  logic [NSUB-1:0]        sout_q, sout_d;
  logic [IDXW-1:0]        bidx_q, bidx_d;
  logic [W-1:0]           bmet_q, bmet_d;
  logic [W-1:0]           a, b;
  logic                   adv1, adv2;

  // Each stage moves when it is empty or the stage after it is moving.
  assign adv2 = !v2_q || bus.out_ready;
  assign adv1 = !v1_q || adv2;

  always_comb begin
    s_d    = '0;
    sout_d = '0;
    a      = '0;
    b      = '0;
    for (int unsigned i = 0; i < NSUB; i++) begin
      a = m1_q[i*W +: W];
      b = m1_q[(i+NSUB)*W +: W];
      if (TIE_UPPER ? (a < b) : (a <= b)) begin
        s_d[i*W +: W] = a;
        sout_d[i]     = 1'b0;
      end else begin
        s_d[i*W +: W] = b;
        sout_d[i]     = 1'b1;
      end
    end
    // Strict compare keeps the lowest index on ties, regardless of TIE_HI.
    bmet_d = s_d[W-1:0];
    bidx_d = '0;
    for (int unsigned i = 1; i < NSUB; i++) begin
      if (s_d[i*W +: W] < bmet_d) begin
        bmet_d = s_d[i*W +: W];
        bidx_d = IDXW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      m1_q   <= '0;
      s_q    <= '0;
      sout_q <= '0;
      bidx_q <= '0;
      bmet_q <= '0;
    end else begin
      if (adv1) begin
        m1_q <= bus.in_metrics;
        v1_q <= bus.in_valid;
      end
      if (adv2) begin
        s_q    <= s_d;
        sout_q <= sout_d;
        bidx_q <= bidx_d;
        bmet_q <= bmet_d;
        v2_q   <= v1_q;
      end
    end
  end

  assign bus.in_ready    = adv1;
  assign bus.out_valid   = v2_q;
  assign bus.s           = s_q;
  assign bus.sout        = sout_q;
  assign bus.best_idx    = bidx_q;
  assign bus.best_metric = bmet_q;
endmodule
